mips_multicycle_control: RTL and testbench

- Control FSM for the multi-cycle MIPS datapath. It replaces the single-cycle combinational control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps over one shared memory port and one ALU.
- Adds BNE support, a variable-latency memory handshake (mem_ready), illegal-instruction detection and a retire pulse.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes/enables.

---
 rtl/mips_mc_pkg.sv | 74 +++++++
 rtl/mips_multicycle_control_if.sv | 42 ++++
 rtl/mips_multicycle_control_alu_decoder.sv | 24 ++
 rtl/mips_multicycle_control.sv | 140 ++++++++++++++
 tb/tb_mips_multicycle_control.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// opcodes, funct codes, ALU codes, states and mux selects.
package mips_mc_pkg;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int ALUC_W  = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_4     = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic              mem_req;
    logic              iord;
    logic              mem_write;
    logic              ir_write;
    logic              pc_en;
    logic [1:0]        pc_src;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUC_W-1:0] alu_control;
    logic              illegal;
    logic              instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the instruction register/datapath and the
// control FSM. master = control side, slave = datapath side.
interface mips_multicycle_control_if;
  import mips_mc_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;

  logic               mem_req;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUC_W-1:0]  alu_control;
  logic               illegal;
  logic               instr_done;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, mem_write, ir_write,
    output pc_en, pc_src, reg_dst, mem_to_reg,
    output reg_write, alu_src_a, alu_src_b,
    output alu_control, illegal, instr_done
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, mem_write, ir_write,
    input  pc_en, pc_src, reg_dst, mem_to_reg,
    input  reg_write, alu_src_a, alu_src_b,
    input  alu_control, illegal, instr_done
  );

endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// R-type funct to ALU operation; unknown funct falls back
// to ADD and flags funct_illegal_o.
module mc_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALUC_W-1:0]  alu_control_o,
  output logic               funct_illegal_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    unique case (1'b1)
      (funct_i == FN_ADD): alu_control_o = ALU_ADD;
      (funct_i == FN_SUB): alu_control_o = ALU_SUB;
      (funct_i == FN_AND): alu_control_o = ALU_AND;
      (funct_i == FN_OR):  alu_control_o = ALU_OR;
      (funct_i == FN_SLT): alu_control_o = ALU_SLT;
      default:             funct_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode,
// execute, memory and writeback over one memory port.
module mips_multicycle_control
  import mips_mc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  state_e            state_q;
  state_e            state_d;
  ctrl_t             c;
  ctrl_t             g;
  logic [ALUC_W-1:0] alu_fn;
  logic              fn_bad;

  mc_alu_decoder u_dec (
    .funct_i         (bus.funct),
    .alu_control_o   (alu_fn),
    .funct_illegal_o (fn_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    c             = '0;
    c.alu_control = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_4;
        c.pc_src    = PC_ALU;
        c.ir_write  = bus.mem_ready;
        c.pc_en     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        unique case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default: begin
            c.illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_req    = 1'b1;
        c.iord       = 1'b1;
        c.mem_write  = bus.mem_ready;
        c.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_control = alu_fn;
        c.illegal     = fn_bad;
        state_d       = fn_bad ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_control = ALU_SUB;
        c.pc_src      = PC_ALUOUT;
        c.pc_en       = (bus.opcode == OP_BNE) ? ~bus.zero
                                               : bus.zero;
        c.instr_done  = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        c.pc_src     = PC_JUMP;
        c.pc_en      = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset must silence every strobe at once, not at the next edge.
  assign g = rst_n ? c : '0;

  assign bus.mem_req     = g.mem_req;
  assign bus.iord        = g.iord;
  assign bus.mem_write   = g.mem_write;
  assign bus.ir_write    = g.ir_write;
  assign bus.pc_en       = g.pc_en;
  assign bus.pc_src      = g.pc_src;
  assign bus.reg_dst     = g.reg_dst;
  assign bus.mem_to_reg  = g.mem_to_reg;
  assign bus.reg_write   = g.reg_write;
  assign bus.alu_src_a   = g.alu_src_a;
  assign bus.alu_src_b   = g.alu_src_b;
  assign bus.alu_control = g.alu_control;
  assign bus.illegal     = g.illegal;
  assign bus.instr_done  = g.instr_done;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction cycle
// model builds expected output sequences, random programs.
module tb_mips_multicycle_control;
  import mips_mc_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal;
    logic       instr_done;
  } ob_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ob_t   eq[$];
  ob_t   mq[$];
  bit    rq[$];
  string tq[$];

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input ob_t got,
                       input ob_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic ob_t obs();
    ob_t o;
    o.mem_req     = bus.mem_req;
    o.iord        = bus.iord;
    o.mem_write   = bus.mem_write;
    o.ir_write    = bus.ir_write;
    o.pc_en       = bus.pc_en;
    o.pc_src      = bus.pc_src;
    o.reg_dst     = bus.reg_dst;
    o.mem_to_reg  = bus.mem_to_reg;
    o.reg_write   = bus.reg_write;
    o.alu_src_a   = bus.alu_src_a;
    o.alu_src_b   = bus.alu_src_b;
    o.alu_control = bus.alu_control;
    o.illegal     = bus.illegal;
    o.instr_done  = bus.instr_done;
    return o;
  endfunction

  function automatic ob_t en_mask();
    ob_t m = '0;
    m.mem_req    = 1'b1;
    m.mem_write  = 1'b1;
    m.ir_write   = 1'b1;
    m.pc_en      = 1'b1;
    m.reg_write  = 1'b1;
    m.illegal    = 1'b1;
    m.instr_done = 1'b1;
    return m;
  endfunction

  function automatic ob_t alu_care(input ob_t m);
    ob_t r = m;
    r.alu_src_a   = 1'b1;
    r.alu_src_b   = 2'b11;
    r.alu_control = 3'b111;
    return r;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011,
                      6'b000100, 6'b000101, 6'b001000,
                      6'b000010};
  endfunction

  function automatic bit f2alu(input logic [5:0] fn,
                               output logic [2:0] a);
    a = 3'b010;
    case (fn)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic push(input string t, input ob_t e,
                      input ob_t m, input bit r);
    tq.push_back(t);
    eq.push_back(e);
    mq.push_back(m);
    rq.push_back(r);
  endtask

  function automatic bit rnd();
    return 1'($urandom % 2);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic gen(input logic [5:0] op,
                     input logic [5:0] fn, input bit z,
                     input int fw, input int mw);
    ob_t e;
    ob_t m;
    logic [2:0] a;
    bit ok;
    for (int k = 0; k <= fw; k++) begin
      e = '0;
      m = alu_care(en_mask());
      m.iord = 1'b1;
      m.pc_src = 2'b11;
      e.mem_req = 1'b1;
      e.alu_src_b = 2'b01;
      e.alu_control = 3'b010;
      e.ir_write = (k == fw);
      e.pc_en = (k == fw);
      push("fetch", e, m, k == fw);
    end
    e = '0;
    m = alu_care(en_mask());
    e.alu_src_b = 2'b11;
    e.alu_control = 3'b010;
    e.illegal = !legal_op(op);
    push("decode", e, m, rnd());
    if (!legal_op(op)) return;
    case (op)
      6'b100011, 6'b101011: begin
        e = '0;
        m = alu_care(en_mask());
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        e.alu_control = 3'b010;
        push("memadr", e, m, rnd());
        for (int k = 0; k <= mw; k++) begin
          e = '0;
          m = en_mask();
          m.iord = 1'b1;
          e.mem_req = 1'b1;
          e.iord = 1'b1;
          if (op == 6'b101011) begin
            e.mem_write = (k == mw);
            e.instr_done = (k == mw);
          end
          push(op == 6'b101011 ? "memwr" : "memrd", e, m,
               k == mw);
        end
        if (op == 6'b100011) begin
          e = '0;
          m = en_mask();
          m.reg_dst = 1'b1;
          m.mem_to_reg = 1'b1;
          e.reg_write = 1'b1;
          e.mem_to_reg = 1'b1;
          e.instr_done = 1'b1;
          push("memwb", e, m, rnd());
        end
      end
      6'b000000: begin
        ok = f2alu(fn, a);
        e = '0;
        m = alu_care(en_mask());
        e.alu_src_a = 1'b1;
        e.alu_control = a;
        e.illegal = !ok;
        push("exec", e, m, rnd());
        if (ok) begin
          e = '0;
          m = en_mask();
          m.reg_dst = 1'b1;
          m.mem_to_reg = 1'b1;
          e.reg_write = 1'b1;
          e.reg_dst = 1'b1;
          e.instr_done = 1'b1;
          push("aluwb", e, m, rnd());
        end
      end
      6'b000100, 6'b000101: begin
        e = '0;
        m = alu_care(en_mask());
        m.pc_src = 2'b11;
        e.alu_src_a = 1'b1;
        e.alu_control = 3'b110;
        e.pc_src = 2'b01;
        e.pc_en = (op == 6'b000100) ? z : !z;
        e.instr_done = 1'b1;
        push("branch", e, m, rnd());
      end
      6'b001000: begin
        e = '0;
        m = alu_care(en_mask());
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        e.alu_control = 3'b010;
        push("addiex", e, m, rnd());
        e = '0;
        m = en_mask();
        m.reg_dst = 1'b1;
        m.mem_to_reg = 1'b1;
        e.reg_write = 1'b1;
        e.instr_done = 1'b1;
        push("addiwb", e, m, rnd());
      end
      default: begin
        e = '0;
        m = en_mask();
        m.pc_src = 2'b11;
        e.pc_src = 2'b10;
        e.pc_en = 1'b1;
        e.instr_done = 1'b1;
        push("jump", e, m, rnd());
      end
    endcase
  endtask

  task automatic run_q(input int n);
    int i = 0;
    while (eq.size() > 0 && i < n) begin
      string t;
      ob_t e;
      ob_t m;
      t = tq.pop_front();
      e = eq.pop_front();
      m = mq.pop_front();
      bus.mem_ready = rq.pop_front();
      @(negedge clk);
      check(t, obs() & m, e & m);
      @(posedge clk);
      #1;
      i++;
    end
    eq.delete();
    mq.delete();
    rq.delete();
    tq.delete();
  endtask

  task automatic instr(input logic [5:0] op,
                       input logic [5:0] fn, input bit z,
                       input int fw, input int mw);
    bus.opcode = op;
    bus.funct = fn;
    bus.zero = z;
    gen(op, fn, z, fw, mw);
    run_q(1000);
  endtask

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010};
  logic [5:0] op_tab [7] = '{6'b000000, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b001000,
                             6'b000010};

  initial begin
    ob_t fe;
    ob_t fm;
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #3;
    check("rst_init", obs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while a load waits in MEMRD.
    bus.opcode = 6'b100011;
    bus.funct = 6'b0;
    gen(6'b100011, 6'b0, 1'b0, 0, 3);
    run_q(4);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_memrd", obs(), '0);
    @(posedge clk);
    #1;
    check("rst_hold", obs(), '0);
    #2;
    rst_n = 1'b1;
    #1;
    fe = '0;
    fm = en_mask();
    fm.iord = 1'b1;
    fe.mem_req = 1'b1;
    check("rst_fetch", obs() & fm, fe);
    @(posedge clk);
    #1;

    instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    instr(6'b000101, 6'b000000, 1'b1, 0, 0);
    instr(6'b101011, 6'b000000, 1'b0, 1, 2);
    instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    instr(6'b000000, 6'b000111, 1'b0, 0, 0);
    instr(6'b001000, 6'b000000, 1'b0, 2, 0);
    instr(6'b000010, 6'b000000, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int sel;
      sel = $urandom_range(0, 9);
      fn = 6'($urandom);
      if (sel < 7) op = op_tab[sel];
      else if (sel == 7) op = 6'($urandom);
      else begin
        op = 6'b000000;
        fn = fn_tab[$urandom_range(0, 4)];
      end
      instr(op, fn, 1'($urandom % 2), $urandom_range(0, 2),
            $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks,
             failures);
    $finish;
  end

endmodule
